// File: rtl/spi_pkg.sv
// SPI shared definitions: mode encoding, CPOL/CPHA extraction, slave FSM states.
// Imported by the slave top and shared with the SPI master.
package spi_pkg;

   typedef enum logic [1:0] {
      MODE0 = 2'd0,
      MODE1 = 2'd1,
      MODE2 = 2'd2,
      MODE3 = 2'd3
   } spi_mode_e;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } spi_state_e;

   function automatic logic spi_cpol(spi_mode_e m);
      return (m == MODE2) || (m == MODE3);
   endfunction

   function automatic logic spi_cpha(spi_mode_e m);
      return (m == MODE1) || (m == MODE3);
   endfunction

endpackage

// File: rtl/spi_slave_if.sv
// SPI link pins between one master and one slave.
// Ports: SClk/SS/MOSI from master, MISO/MISO_oe from slave.
interface spi_slave_if;

   logic SClk;
   logic SS;
   logic MOSI;
   logic MISO;
   logic MISO_oe;

   modport master (
      output SClk, SS, MOSI,
      input  MISO, MISO_oe
   );

   modport slave (
      input  SClk, SS, MOSI,
      output MISO, MISO_oe
   );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with rise/fall detect on the synchronised value.
// Ports: Clk, Reset_n, rst_val_i (idle level), d_i (async pin), rise_o, fall_o.
module spi_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic rst_val_i,
   input  logic d_i,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   s_w;

   assign s_w = sync_q[SYNC_STAGES-1];

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         sync_q <= {SYNC_STAGES{rst_val_i}};
         prev_q <= rst_val_i;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
         prev_q <= s_w;
      end
   end

   assign rise_o = s_w & ~prev_q;
   assign fall_o = ~s_w & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave endpoint, fully oversampled on Clk, all four modes.
// Ports: Clk, Reset_n, MODE, TxData/TxLoad/TxReady, RxData/RxValid, FrameErr, Busy, spi (pins).
module spi_slave
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic [1:0]            MODE,
   input  logic [DATA_WIDTH-1:0] TxData,
   input  logic                  TxLoad,
   output logic                  TxReady,
   output logic [DATA_WIDTH-1:0] RxData,
   output logic                  RxValid,
   output logic                  FrameErr,
   output logic                  Busy,
   spi_slave_if.slave            spi
);

   localparam int CW = $clog2(DATA_WIDTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DATA_WIDTH);

   spi_state_e state_q, state_d;

   logic [1:0]             mode_q;
   logic [CW-1:0]          cnt_q;
   logic [DATA_WIDTH-1:0]  rx_sr_q, tx_sr_q, txbuf_q, rx_data_q;
   logic                   txfull_q, rx_valid_q, ferr_q;
   logic [SYNC_STAGES-1:0] mosi_q;

   logic sclk_rise, sclk_fall, ss_rise, ss_fall;
   logic cpol_w, cpha_w, lead_w, trail_w, cap_w, shf_w;
   logic xfer, abort, done, live, cap_en, shf_en;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .rst_val_i (spi_cpol(spi_mode_e'(MODE))),
      .d_i       (spi.SClk),
      .rise_o    (sclk_rise),
      .fall_o    (sclk_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ss (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .rst_val_i (1'b1),
      .d_i       (spi.SS),
      .rise_o    (ss_rise),
      .fall_o    (ss_fall)
   );

   assign cpol_w  = spi_cpol(spi_mode_e'(mode_q));
   assign cpha_w  = spi_cpha(spi_mode_e'(mode_q));
   assign lead_w  = cpol_w ? sclk_fall : sclk_rise;
   assign trail_w = cpol_w ? sclk_rise : sclk_fall;
   assign cap_w   = cpha_w ? trail_w : lead_w;
   assign shf_w   = cpha_w ? lead_w : trail_w;

   always_ff @(posedge Clk) begin
      if (!Reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      xfer    = 1'b0;
      abort   = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (ss_fall) begin
               state_d = ACTIVE;
               xfer    = 1'b1;
            end
         end
         ACTIVE: begin
            if (ss_rise) begin
               state_d = IDLE;
               abort   = (cnt_q != '0);
            end else if (cnt_q == FULL) begin
               done = 1'b1;
               xfer = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // SS rise beats any coincident SClk edge.
   assign live   = (state_q == ACTIVE) && !ss_rise && !done;
   assign cap_en = live && cap_w;
   // No shift at count 0: CPHA=1 first shift edge shows the loaded MSB,
   // CPHA=0 edge after the last capture must keep the new MSB.
   assign shf_en = live && shf_w && (cnt_q != '0);

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         mode_q     <= MODE;
         mosi_q     <= '0;
         cnt_q      <= '0;
         rx_sr_q    <= '0;
         tx_sr_q    <= '0;
         txbuf_q    <= '0;
         txfull_q   <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         mosi_q     <= {mosi_q[SYNC_STAGES-2:0], spi.MOSI};
         rx_valid_q <= done;
         ferr_q     <= abort;
         if (state_q == IDLE) mode_q <= MODE;
         if (done) rx_data_q <= rx_sr_q;
         if (done || abort) begin
            cnt_q <= '0;
         end else if (cap_en) begin
            cnt_q   <= cnt_q + CW'(1);
            rx_sr_q <= {rx_sr_q[DATA_WIDTH-2:0], mosi_q[SYNC_STAGES-1]};
         end
         if (xfer) tx_sr_q <= txfull_q ? txbuf_q : '0;
         else if (shf_en) tx_sr_q <= {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
         // Load after transfer so a same-cycle load fills the next frame.
         if (TxLoad && !txfull_q) begin
            txbuf_q  <= TxData;
            txfull_q <= 1'b1;
         end else if (xfer) begin
            txfull_q <= 1'b0;
         end
      end
   end

   assign TxReady     = ~txfull_q;
   assign RxData      = rx_data_q;
   assign RxValid     = rx_valid_q;
   assign FrameErr    = ferr_q;
   assign Busy        = (state_q == ACTIVE);
   assign spi.MISO    = tx_sr_q[DATA_WIDTH-1];
   assign spi.MISO_oe = (state_q == ACTIVE);

endmodule
